// File: rtl/sint_accum_pkg.sv
// Shared definitions for the signed difference accumulator.
//   state_t     : frame FSM states (ACCUM collects samples, DONE presents a result)
//   SAT_MAX/MIN : clamp limits of an acc_width-bit two's-complement value
//   sext32      : sign-extends the low w bits of a word to 32 bits
// All arithmetic helpers work in 32 bits, so accumulator widths up to 30 bits
// are handled exactly (the widest sum then still fits without wrapping).
package sint_accum_pkg;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    function automatic logic signed [31:0] SAT_MAX(input int acc_width);
        return (32'sd1 <<< (acc_width - 1)) - 32'sd1;
    endfunction

    function automatic logic signed [31:0] SAT_MIN(input int acc_width);
        return -(32'sd1 <<< (acc_width - 1));
    endfunction

    // Move bit w-1 up to bit 31, then arithmetic-shift it back down.
    function automatic logic signed [31:0] sext32(input logic [31:0] v, input int w);
        logic signed [31:0] t;
        t = signed'(v << (32 - w));
        return t >>> (32 - w);
    endfunction

endpackage

// File: rtl/sint_sat_add.sv
// Combinational signed saturating adder.
//   a   : ACC_WIDTH-bit signed accumulator operand
//   b   : WIDTH-bit signed sample operand
//   sum : a + b clamped to the ACC_WIDTH-bit signed range
//   sat : high when the clamp was applied
module sint_sat_add
    import sint_accum_pkg::*;
#(
    parameter int WIDTH     = 7,
    parameter int ACC_WIDTH = 12
) (
    input  logic [ACC_WIDTH-1:0] a,
    input  logic [WIDTH-1:0]     b,
    output logic [ACC_WIDTH-1:0] sum,
    output logic                 sat
);

    localparam logic signed [31:0] MAX_C = SAT_MAX(ACC_WIDTH);
    localparam logic signed [31:0] MIN_C = SAT_MIN(ACC_WIDTH);

    // Sum is formed exactly in 32 bits, so overflow shows up as a value
    // outside the narrow range rather than as a wrapped result.
    logic signed [31:0] wide;

    always_comb begin
        wide = sext32(32'(a), ACC_WIDTH) + sext32(32'(b), WIDTH);
        sum  = wide[ACC_WIDTH-1:0];
        sat  = 1'b0;
        if (wide > MAX_C) begin
            sum = MAX_C[ACC_WIDTH-1:0];
            sat = 1'b1;
        end else if (wide < MIN_C) begin
            sum = MIN_C[ACC_WIDTH-1:0];
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/sint_diff_accum.sv
// Windowed accumulator for signed differences.
// Collects N samples over a valid/ready handshake into a saturating
// accumulator, presents the frame sum, then clears for the next frame.
//   CLK, ASYNCRESET : clock, asynchronous active-high reset
//   I, I_valid      : signed sample input and its valid
//   I_ready         : high while collecting (ACCUM state)
//   O, O_valid      : frame sum and its valid (DONE state)
//   O_ready         : downstream takes O
//   O_sat           : sticky clamp flag for the current/presented frame
//   count           : samples accepted so far in this frame
module sint_diff_accum
    import sint_accum_pkg::*;
#(
    parameter int WIDTH     = 7,
    parameter int ACC_WIDTH = 12,
    parameter int N         = 8,
    parameter int CNT_WIDTH = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 CLK,
    input  logic                 ASYNCRESET,
    input  logic [WIDTH-1:0]     I,
    input  logic                 I_valid,
    output logic                 I_ready,
    output logic [ACC_WIDTH-1:0] O,
    output logic                 O_valid,
    input  logic                 O_ready,
    output logic                 O_sat,
    output logic [CNT_WIDTH-1:0] count
);

    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(N - 1);

    state_t               state;
    state_t               state_next;
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] add_sum;
    logic                 add_sat;
    logic                 accept;
    logic                 last;
    logic                 handoff;

    sint_sat_add #(
        .WIDTH    (WIDTH),
        .ACC_WIDTH(ACC_WIDTH)
    ) u_add (
        .a  (acc),
        .b  (I),
        .sum(add_sum),
        .sat(add_sat)
    );

    assign accept  = I_valid & I_ready;
    assign handoff = O_valid & O_ready;
    assign last    = (count == LAST_CNT);

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        I_ready    = 1'b0;
        O_valid    = 1'b0;
        case (state)
            ACCUM: begin
                I_ready = 1'b1;
                if (I_valid && last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                O_valid = 1'b1;
                if (O_ready) begin
                    state_next = ACCUM;
                end
            end
            default: state_next = ACCUM;
        endcase
    end

    // acc keeps the final sum while DONE and is only cleared at handoff;
    // O is not cleared so it keeps its last value after the handoff.
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            acc   <= '0;
            O     <= '0;
            O_sat <= 1'b0;
            count <= '0;
        end else if (accept) begin
            acc   <= add_sum;
            O_sat <= O_sat | add_sat;
            if (last) begin
                O     <= add_sum;
                count <= '0;
            end else begin
                count <= count + CNT_WIDTH'(1);
            end
        end else if (handoff) begin
            acc   <= '0;
            O_sat <= 1'b0;
        end
    end

endmodule
